// File: rtl/mac_feeder.sv
// ---------------------------------------------------------------------------
// mac_feeder
//   Operand sequencer and result collector for one DSP48 MACC slice.
//   Accepts a command (start/len), streams len operand pairs into the MAC,
//   waits for the MAC pipeline to drain, then returns one dot-product result
//   on a valid/ready output.
//
//   Build option: define MAC_FEEDER_SAT_EN to saturate the accumulator to
//   signed OUT_WIDTH. Otherwise the result is a plain truncation.
//
// Ports
//   clk                   rising-edge clock
//   rst                   asynchronous reset, active low
//   start, len            command strobe (sampled in IDLE) and pair count
//   busy                  high whenever not IDLE
//   in_valid/in_ready     operand stream handshake
//   in_a, in_b            signed operand pair
//   mac_a, mac_b          registered operands to the MAC
//   mac_en                MAC clock enable
//   mac_rst               MAC accumulator clear, active high
//   mac_p                 MAC accumulator output
//   res_valid/res_ready   result stream handshake
//   res_data              dot-product result
// ---------------------------------------------------------------------------
module mac_feeder #(
    parameter int DATA_WIDTH  = 8,
    parameter int ACC_WIDTH   = 16,
    parameter int OUT_WIDTH   = 8,
    parameter int LEN_WIDTH   = 8,
    parameter int MAC_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    output logic [DATA_WIDTH-1:0] mac_a,
    output logic [DATA_WIDTH-1:0] mac_b,
    output logic                  mac_en,
    output logic                  mac_rst,
    input  logic [ACC_WIDTH-1:0]  mac_p,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [OUT_WIDTH-1:0]  res_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_HOLD
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [LEN_WIDTH-1:0]   r_len;
    logic [LEN_WIDTH-1:0]   r_cnt;
    logic [2:0]             r_drain;
    logic                   w_in_xfer;
    logic                   w_last;
    logic [OUT_WIDTH-1:0]   w_res;

    assign w_in_xfer = (r_state == S_FEED) && in_valid;
    assign w_last    = w_in_xfer && ((r_cnt + 1'b1) == r_len);

    // State-decoded outputs: no combinational path from in_valid/res_ready.
    assign busy      = (r_state != S_IDLE);
    assign in_ready  = (r_state == S_FEED);
    assign mac_rst   = (r_state == S_CLEAR);
    assign res_valid = (r_state == S_HOLD);

`ifdef MAC_FEEDER_SAT_EN
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    always_comb begin
        w_res = mac_p[OUT_WIDTH-1:0];
        if ($signed(mac_p) > SAT_MAX)
            w_res = SAT_MAX[OUT_WIDTH-1:0];
        else if ($signed(mac_p) < SAT_MIN)
            w_res = SAT_MIN[OUT_WIDTH-1:0];
    end
`else
    logic w_unused_hi;
    assign w_unused_hi = ^mac_p;
    assign w_res       = mac_p[OUT_WIDTH-1:0];
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = (len != '0) ? S_CLEAR : S_HOLD;
            S_CLEAR: w_next = S_FEED;
            S_FEED:  if (w_last) w_next = S_DRAIN;
            S_DRAIN: if (r_drain == '0) w_next = S_HOLD;
            S_HOLD:  if (res_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_len    <= '0;
            r_cnt    <= '0;
            r_drain  <= '0;
            mac_a    <= '0;
            mac_b    <= '0;
            mac_en   <= 1'b0;
            res_data <= '0;
        end else begin
            mac_en <= w_in_xfer;
            if (w_in_xfer) begin
                mac_a <= in_a;
                mac_b <= in_b;
                r_cnt <= r_cnt + 1'b1;
            end
            if ((r_state == S_IDLE) && start) begin
                r_len <= len;
                r_cnt <= '0;
                if (len == '0) res_data <= '0;
            end
            // Drain counter covers the MAC pipeline; sampling happens the
            // cycle after it reaches zero so P has settled.
            if (w_last) r_drain <= 3'(MAC_LATENCY);
            if (r_state == S_DRAIN) begin
                if (r_drain == '0) res_data <= w_res;
                else               r_drain  <= r_drain - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mac_feeder.sv
module tb_mac_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    // DUT 1: default parameters (MAC_LATENCY = 1)
    logic        start = 1'b0;
    logic [7:0]  len = '0;
    logic        busy;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;
    logic [7:0]  mac_a, mac_b;
    logic        mac_en, mac_rst;
    logic [15:0] mac_p;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [7:0]  res_data;

    // DUT 2: MAC_LATENCY = 3
    logic        s_start = 1'b0;
    logic [7:0]  s_len = '0;
    logic        s_busy;
    logic        s_in_valid = 1'b0;
    logic        s_in_ready;
    logic [7:0]  s_in_a = '0;
    logic [7:0]  s_in_b = '0;
    logic [7:0]  s_mac_a, s_mac_b;
    logic        s_mac_en, s_mac_rst;
    logic [15:0] s_mac_p;
    logic        s_res_valid;
    logic        s_res_ready = 1'b0;
    logic [7:0]  s_res_data;

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;
    int rst_cnt = 0;

    always #5 clk = ~clk;

    mac_feeder dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .mac_a(mac_a), .mac_b(mac_b), .mac_en(mac_en), .mac_rst(mac_rst),
        .mac_p(mac_p), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data)
    );

    mac_feeder #(.MAC_LATENCY(3)) dut3 (
        .clk(clk), .rst(rst), .start(s_start), .len(s_len), .busy(s_busy),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_a(s_in_a), .in_b(s_in_b),
        .mac_a(s_mac_a), .mac_b(s_mac_b), .mac_en(s_mac_en), .mac_rst(s_mac_rst),
        .mac_p(s_mac_p), .res_valid(s_res_valid), .res_ready(s_res_ready),
        .res_data(s_res_data)
    );

    // Behavioural MAC, latency 1: P follows the accumulator register.
    logic signed [15:0] acc1 = '0;
    always @(posedge clk) begin
        if (mac_rst)     acc1 <= '0;
        else if (mac_en) acc1 <= acc1 + $signed(mac_a) * $signed(mac_b);
    end
    assign mac_p = acc1;

    // Behavioural MAC, latency 3: accumulator plus two output stages.
    logic signed [15:0] acc3 = '0, d1 = '0, d2 = '0;
    always @(posedge clk) begin
        if (s_mac_rst)     acc3 <= '0;
        else if (s_mac_en) acc3 <= acc3 + $signed(s_mac_a) * $signed(s_mac_b);
        d1 <= acc3;
        d2 <= d1;
    end
    assign s_mac_p = d2;

    always @(posedge clk) begin
        if (mac_en)  en_cnt  <= en_cnt + 1;
        if (mac_rst) rst_cnt <= rst_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [7:0] n);
        len   = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b);
        int n;
        in_a = a;
        in_b = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin tick(); n++; end
        if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_res(output int lat);
        lat = 0;
        while (!res_valid && lat < 20) begin tick(); lat++; end
    endtask

    task automatic accept();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        int lat, e0, r0;
        logic [7:0] held;

        // Reset state
        tick(); tick();
        check("reset_outputs", 32'({in_ready, busy, mac_a, mac_b, mac_en, mac_rst, res_valid, res_data}), 32'd0);
        rst = 1'b1;
        tick();

        // Basic dot product: (2,3),(4,5),(-1,6) = 20
        e0 = en_cnt; r0 = rst_cnt;
        do_start(8'd3);
        check("basic_clear", 32'({busy, mac_rst, in_ready}), 32'b110);
        send(8'd2, 8'd3);
        send(8'd4, 8'd5);
        send(8'hFF, 8'd6);
        wait_res(lat);
        check("basic_latency", 32'(lat), 32'd2);
        check("basic_data", 32'(res_data), 32'd20);
        check("basic_en_pulses", 32'(en_cnt - e0), 32'd3);
        check("basic_rst_pulses", 32'(rst_cnt - r0), 32'd1);
        accept();
        check("basic_idle", 32'({busy, res_valid}), 32'd0);

        // Zero length
        e0 = en_cnt; r0 = rst_cnt;
        do_start(8'd0);
        check("zero_valid", 32'(res_valid), 32'd1);
        check("zero_data", 32'(res_data), 32'd0);
        accept();
        check("zero_no_mac", 32'((en_cnt - e0) + (rst_cnt - r0)), 32'd0);

        // Overflow: 12500
        do_start(8'd2);
        send(8'd100, 8'd100);
        send(8'd50, 8'd50);
        wait_res(lat);
`ifdef MAC_FEEDER_SAT_EN
        check("overflow_data", 32'(res_data), 32'd127);
`else
        check("overflow_data", 32'(res_data), 32'hD4);
`endif
        accept();

        // Backpressure: bubbles on input, res_ready low, start pulses in HOLD
        e0 = en_cnt;
        do_start(8'd4);
        send(8'd1, 8'd1); tick();
        send(8'd2, 8'd2); tick();
        send(8'd3, 8'd3); tick();
        send(8'd4, 8'd4);
        wait_res(lat);
        check("bp_data", 32'(res_data), 32'd30);
        held = res_data;
        for (int i = 0; i < 5; i++) begin
            len = 8'd1;
            start = 1'b1;
            tick();
            check("bp_hold", 32'({res_valid, res_data}), 32'({1'b1, held}));
        end
        start = 1'b0;
        check("bp_en_pulses", 32'(en_cnt - e0), 32'd4);
        accept();
        tick();
        check("bp_start_ignored", 32'({busy, res_valid}), 32'd0);

        // Reset mid-operation after 2 of 4 pairs
        do_start(8'd4);
        send(8'd9, 8'd9);
        send(8'd9, 8'd9);
        rst = 1'b0;
        #1;
        check("midrst_outputs", 32'({in_ready, busy, mac_a, mac_b, mac_en, mac_rst, res_valid, res_data}), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        do_start(8'd1);
        send(8'd7, 8'hFD);
        wait_res(lat);
        check("midrst_data", 32'(res_data), 32'hEB);
        accept();

        // Latency sweep: MAC_LATENCY = 3, (1,1),(2,2) = 5
        s_len = 8'd2;
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
        s_in_a = 8'd1; s_in_b = 8'd1; s_in_valid = 1'b1;
        lat = 0;
        while (!s_in_ready && lat < 20) begin tick(); lat++; end
        check("lat3_first_ready", 32'(lat), 32'd1);
        tick();
        s_in_a = 8'd2; s_in_b = 8'd2;
        tick();
        s_in_valid = 1'b0;
        lat = 0;
        while (!s_res_valid && lat < 20) begin tick(); lat++; end
        check("lat3_latency", 32'(lat), 32'd4);
        check("lat3_data", 32'(s_res_data), 32'd5);
        s_res_ready = 1'b1;
        tick();
        s_res_ready = 1'b0;
        check("lat3_idle", 32'(s_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
